// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: stall bus layout, branch/IF-ID bus widths, reset vector.
// No logic; referenced by the fetch unit, its hold buffer and the bus interface.
// Field layouts here must stay in step with decode's unpacking of the same buses.
package fetch_unit_pkg;

    localparam int STALL_WD    = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Chosen so that the first sequential fetch after reset lands on 0xBFC0_0000.
    localparam logic [31:0] RESET_VEC = 32'hBFBF_FFFC;

    // Stall bus bit positions.
    localparam int STALL_PC = 0;
    localparam int STALL_ID = 1;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    typedef enum logic {
        BUF_PASS = 1'b0,
        BUF_HOLD = 1'b1
    } buf_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: stall/branch inputs, instruction SRAM port, IF->ID outputs.
// Pure wiring, no latency.
// Backpressure is carried by the stall field; there is no valid/ready pair here.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [STALL_WD-1:0] stall;
    br_bus_t             br_bus;
    logic [31:0]         inst_sram_rdata;
    logic                inst_sram_en;
    logic [3:0]          inst_sram_wen;
    logic [31:0]         inst_sram_addr;
    logic [31:0]         inst_sram_wdata;
    if_to_id_t           if_to_id_bus;
    logic [31:0]         if_inst;
    logic                fetch_adel;
    logic [31:0]         fetch_cnt;

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
               if_to_id_bus, if_inst, fetch_adel, fetch_cnt
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
               if_to_id_bus, if_inst, fetch_adel, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit_inst_hold_buf.sv
// Instruction hold buffer: passes SRAM read data through, or replays a captured word while decode stalls.
// Zero latency in PASS (combinational), captured word appears the cycle after hold asserts.
// hold=1 freezes the captured word; the first hold=0 cycle still replays it, then the buffer empties.
module inst_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    buf_state_e  state;
    logic [31:0] buf_reg;

    // Capture once on entering hold; never overwrite while holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUF_PASS;
            buf_reg <= '0;
        end else begin
            case (state)
                BUF_PASS: begin
                    if (hold) begin
                        state   <= BUF_HOLD;
                        buf_reg <= din;
                    end
                end
                BUF_HOLD: begin
                    if (!hold) begin
                        state <= BUF_PASS;
                    end
                end
                default: state <= BUF_PASS;
            endcase
        end
    end

    assign dout = (state == BUF_HOLD) ? buf_reg : din;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, branch redirect (with deferral across PC stall), fetch counter.
// One-cycle redirect latency; SRAM data returns one cycle after the request.
// stall[0] holds PC/ce and defers redirects; stall[1] freezes the delivered instruction.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        br_pend;
    logic [31:0] br_pend_addr;
    logic [31:0] fetch_cnt_reg;
    logic [31:0] next_pc;
    logic        pc_stop;
    logic        id_stop;
    logic        unused_stall;

    assign pc_stop      = (bus.stall[STALL_PC] == STOP);
    assign id_stop      = (bus.stall[STALL_ID] == STOP);
    assign unused_stall = ^bus.stall[STALL_WD-1:2];

    // A deferred redirect outranks a fresh one; otherwise sequential (wraps mod 2^32).
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (br_pend) begin
            next_pc = br_pend_addr;
        end else if (bus.br_bus.br_e) begin
            next_pc = bus.br_bus.br_addr;
        end
    end

    // PC advance, redirect latching while PC is held, and issued-fetch counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_VEC;
            ce_reg        <= 1'b0;
            br_pend       <= 1'b0;
            br_pend_addr  <= '0;
            fetch_cnt_reg <= '0;
        end else if (!pc_stop) begin
            pc_reg  <= next_pc;
            ce_reg  <= 1'b1;
            br_pend <= 1'b0;
            if (ce_reg) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
        end else if (bus.br_bus.br_e) begin
            // Latest branch seen during the stall wins.
            br_pend      <= 1'b1;
            br_pend_addr <= bus.br_bus.br_addr;
        end
    end

    inst_hold_buf u_hold_buf (
        .clk  (clk),
        .rst  (rst),
        .hold (id_stop),
        .din  (bus.inst_sram_rdata),
        .dout (bus.if_inst)
    );

    assign bus.inst_sram_en    = ce_reg;
    assign bus.inst_sram_wen   = 4'b0;
    assign bus.inst_sram_addr  = pc_reg;
    assign bus.inst_sram_wdata = 32'b0;
    assign bus.if_to_id_bus    = '{ce: ce_reg, pc: pc_reg};
    // Misaligned fetches still go out; decode turns the flag into an exception.
    assign bus.fetch_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
    assign bus.fetch_cnt       = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written stall/reset sequences.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] rdata;
        logic        en;
        logic [31:0] addr;
        logic        adel;
        logic [31:0] inst;
        logic [31:0] cnt;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(logic r, logic [5:0] st, logic be, logic [31:0] ba,
                                logic [31:0] rd, logic en, logic [31:0] ad,
                                logic adl, logic [31:0] ins, logic [31:0] cn);
        vec_t v;
        v.rst = r; v.stall = st; v.br_e = be; v.br_addr = ba; v.rdata = rd;
        v.en = en; v.addr = ad; v.adel = adl; v.inst = ins; v.cnt = cn;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic be,
                         input logic [31:0] ba, input logic [31:0] rd);
        rst                 = r;
        bus.stall           = st;
        bus.br_bus.br_e     = be;
        bus.br_bus.br_addr  = ba;
        bus.inst_sram_rdata = rd;
        #1;
    endtask

    task automatic check_all(input string tag, input logic en, input logic [31:0] ad,
                             input logic adl, input logic [31:0] ins, input logic [31:0] cn);
        check({tag, ".en"},    64'(bus.inst_sram_en),   64'(en));
        check({tag, ".addr"},  64'(bus.inst_sram_addr), 64'(ad));
        check({tag, ".ifid"},  64'(bus.if_to_id_bus),   64'({en, ad}));
        check({tag, ".adel"},  64'(bus.fetch_adel),     64'(adl));
        check({tag, ".inst"},  64'(bus.if_inst),        64'(ins));
        check({tag, ".cnt"},   64'(bus.fetch_cnt),      64'(cn));
        check({tag, ".wen"},   64'(bus.inst_sram_wen),  64'(0));
        check({tag, ".wdata"}, 64'(bus.inst_sram_wdata), 64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // rst, stall, br_e, br_addr, rdata | en, addr, adel, if_inst, fetch_cnt
        tbl[0]  = mk(1, 6'h00, 0, 32'h0,          32'hA000_0000, 0, 32'hBFBF_FFFC, 0, 32'hA000_0000, 0);
        tbl[1]  = mk(1, 6'h00, 1, 32'h1234_5678,  32'hA000_0001, 0, 32'hBFBF_FFFC, 0, 32'hA000_0001, 0);
        tbl[2]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0002, 0, 32'hBFBF_FFFC, 0, 32'hA000_0002, 0);
        tbl[3]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0003, 1, 32'hBFC0_0000, 0, 32'hA000_0003, 0);
        tbl[4]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0004, 1, 32'hBFC0_0004, 0, 32'hA000_0004, 1);
        tbl[5]  = mk(0, 6'h00, 1, 32'hBFC0_0100,  32'hA000_0005, 1, 32'hBFC0_0008, 0, 32'hA000_0005, 2);
        tbl[6]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0006, 1, 32'hBFC0_0100, 0, 32'hA000_0006, 3);
        tbl[7]  = mk(0, 6'h00, 1, 32'hBFC0_0102,  32'hA000_0007, 1, 32'hBFC0_0104, 0, 32'hA000_0007, 4);
        tbl[8]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0008, 1, 32'hBFC0_0102, 1, 32'hA000_0008, 5);
        tbl[9]  = mk(0, 6'h00, 0, 32'h0,          32'hA000_0009, 1, 32'hBFC0_0106, 1, 32'hA000_0009, 6);
        tbl[10] = mk(0, 6'h00, 1, 32'hBFC0_0200,  32'hA000_000A, 1, 32'hBFC0_010A, 1, 32'hA000_000A, 7);
        tbl[11] = mk(0, 6'h00, 0, 32'h0,          32'h2402_0001, 1, 32'hBFC0_0200, 0, 32'h2402_0001, 8);
        tbl[12] = mk(0, 6'h02, 0, 32'h0,          32'h2402_0001, 1, 32'hBFC0_0204, 0, 32'h2402_0001, 9);
        tbl[13] = mk(0, 6'h02, 0, 32'h0,          32'hDEAD_BEEF, 1, 32'hBFC0_0208, 0, 32'h2402_0001, 10);
        tbl[14] = mk(0, 6'h00, 0, 32'h0,          32'hDEAD_BEEF, 1, 32'hBFC0_020C, 0, 32'h2402_0001, 11);
        tbl[15] = mk(0, 6'h00, 0, 32'h0,          32'hDEAD_BEEF, 1, 32'hBFC0_0210, 0, 32'hDEAD_BEEF, 12);
        tbl[16] = mk(0, 6'h00, 1, 32'hFFFF_FFFC,  32'hB000_0000, 1, 32'hBFC0_0214, 0, 32'hB000_0000, 13);
        tbl[17] = mk(0, 6'h00, 0, 32'h0,          32'hB000_0001, 1, 32'hFFFF_FFFC, 0, 32'hB000_0001, 14);
        tbl[18] = mk(0, 6'h00, 0, 32'h0,          32'hB000_0002, 1, 32'h0000_0000, 0, 32'hB000_0002, 15);
        tbl[19] = mk(0, 6'h01, 0, 32'h0,          32'hB000_0003, 1, 32'h0000_0004, 0, 32'hB000_0003, 16);
        tbl[20] = mk(0, 6'h01, 0, 32'h0,          32'hB000_0004, 1, 32'h0000_0004, 0, 32'hB000_0004, 16);
        tbl[21] = mk(0, 6'h00, 0, 32'h0,          32'hB000_0005, 1, 32'h0000_0004, 0, 32'hB000_0005, 16);
        tbl[22] = mk(0, 6'h00, 0, 32'h0,          32'hB000_0006, 1, 32'h0000_0008, 0, 32'hB000_0006, 17);

        // One reset edge before the table so registers are defined at row 0.
        drive(1, 6'h00, 0, 32'h0, 32'h0);
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].br_e, tbl[i].br_addr, tbl[i].rdata);
            check_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].adel,
                      tbl[i].inst, tbl[i].cnt);
            tick();
        end
        // After the table: pc = 0x0000000C, fetch_cnt = 18.

        // Stalled branch: target latched in the first stalled cycle, taken after release;
        // a br_e seen in the release cycle is ignored in favour of the pending target.
        drive(0, 6'h03, 1, 32'h8000_0040, 32'hC000_0000);
        check_all("stbr.c1", 1, 32'h0000_000C, 0, 32'hC000_0000, 18);
        tick();
        drive(0, 6'h03, 0, 32'h0, 32'hC000_0001);
        check_all("stbr.c2", 1, 32'h0000_000C, 0, 32'hC000_0000, 18);
        tick();
        drive(0, 6'h03, 0, 32'h0, 32'hC000_0002);
        check_all("stbr.c3", 1, 32'h0000_000C, 0, 32'hC000_0000, 18);
        tick();
        drive(0, 6'h00, 1, 32'h1111_0000, 32'hC000_0003);
        check_all("stbr.rel", 1, 32'h0000_000C, 0, 32'hC000_0000, 18);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'hC000_0004);
        check_all("stbr.tgt", 1, 32'h8000_0040, 0, 32'hC000_0004, 19);
        tick();

        // Two branches during one PC stall: the later target wins, pending clears after use.
        drive(0, 6'h01, 1, 32'h8000_0100, 32'hC000_0005);
        check_all("ovw.c1", 1, 32'h8000_0044, 0, 32'hC000_0005, 20);
        tick();
        drive(0, 6'h01, 1, 32'h8000_0200, 32'hC000_0006);
        check_all("ovw.c2", 1, 32'h8000_0044, 0, 32'hC000_0006, 20);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'hC000_0007);
        check_all("ovw.rel", 1, 32'h8000_0044, 0, 32'hC000_0007, 20);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'hC000_0008);
        check_all("ovw.tgt", 1, 32'h8000_0200, 0, 32'hC000_0008, 21);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'hC000_0009);
        check_all("ovw.seq", 1, 32'h8000_0204, 0, 32'hC000_0009, 22);
        tick();

        // Reset while a redirect is pending and the buffer is holding: both are discarded.
        drive(0, 6'h03, 1, 32'h9000_0000, 32'h0000_0055);
        check_all("rstp.c1", 1, 32'h8000_0208, 0, 32'h0000_0055, 23);
        tick();
        drive(0, 6'h03, 0, 32'h0, 32'h0000_0066);
        check_all("rstp.c2", 1, 32'h8000_0208, 0, 32'h0000_0055, 23);
        tick();
        drive(1, 6'h00, 0, 32'h0, 32'h0000_0077);
        check_all("rstp.r1", 1, 32'h8000_0208, 0, 32'h0000_0055, 23);
        tick();
        drive(1, 6'h00, 0, 32'h0, 32'h0000_0088);
        check_all("rstp.r2", 0, 32'hBFBF_FFFC, 0, 32'h0000_0088, 0);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'h0000_0099);
        check_all("rstp.rel", 0, 32'hBFBF_FFFC, 0, 32'h0000_0099, 0);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'h0000_00AA);
        check_all("rstp.first", 1, 32'hBFC0_0000, 0, 32'h0000_00AA, 0);
        tick();
        drive(0, 6'h00, 0, 32'h0, 32'h0000_00BB);
        check_all("rstp.second", 1, 32'hBFC0_0004, 0, 32'h0000_00BB, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 stall  input  StallBus(6)  bit0 = PC hold, bit1 = IF/ID hold; Stop=1, NoStop=0.
REQ-004 br_bus  input  33  {br_e, br_addr[31:0]} from decode; redirect request, valid combinationally in the cycle decode holds the branch.
REQ-005 inst_sram_rdata  input  32  instruction SRAM read data, valid one cycle after the request.
REQ-006 inst_sram_en  output  1  SRAM request enable.
REQ-007 inst_sram_wen  output  4  constant 4'b0.
REQ-008 inst_sram_addr  output  32  fetch PC.
REQ-009 inst_sram_wdata  output  32  constant 32'b0.
REQ-010 if_to_id_bus  output  IF_TO_ID_WD(33)  {ce, pc[31:0]} of the current fetch.
REQ-011 if_inst  output  32  instruction word delivered to decode, stable across IF/ID stall.
REQ-012 fetch_adel  output  1  current fetch PC misaligned (pc[1:0] != 0).
REQ-013 fetch_cnt  output  32  number of issued fetches since reset.

Function
REQ-014 The block SHALL hold pc_reg and ce_reg; inst_sram_addr = pc_reg, inst_sram_en = ce_reg, if_to_id_bus = {ce_reg, pc_reg}.
REQ-015 next_pc SHALL be: pending redirect address if br_pend; else br_addr if br_e; else pc_reg + 4 (mod 2^32, wraps at 0xFFFFFFFC).
REQ-016 When stall[0]=NoStop, pc_reg <= next_pc and ce_reg <= 1; when stall[0]=Stop, pc_reg and ce_reg SHALL hold.
REQ-017 If br_e=1 while stall[0]=Stop, br_pend <= 1 and br_pend_addr <= br_addr; a later br_e during the same stall SHALL overwrite br_pend_addr.
REQ-018 br_pend SHALL clear in the first cycle with stall[0]=NoStop, in which next_pc = br_pend_addr regardless of br_e.
REQ-019 Branch delay slot: the instruction at the fetch PC in the cycle br_e is sampled SHALL not be cancelled.
REQ-020 Instruction buffer states: PASS (if_inst = inst_sram_rdata), HOLD (if_inst = buf_reg).
REQ-021 PASS->HOLD when stall[1]=Stop and the buffer is empty: buf_reg <= inst_sram_rdata.
REQ-022 HOLD->PASS on the first cycle with stall[1]=NoStop; if_inst SHALL equal buf_reg during that cycle, and the buffer is empty from the next cycle.
REQ-023 In HOLD, buf_reg SHALL not be overwritten.
REQ-024 fetch_adel = ce_reg & (pc_reg[1:0] != 0); a misaligned fetch still issues and is flagged, not suppressed.
REQ-025 fetch_cnt SHALL increment by 1 in each cycle where ce_reg=1 and stall[0]=NoStop, and wrap from 0xFFFFFFFF to 0.
REQ-026 Simultaneous br_e and stall[0]=NoStop with no pending redirect: br_addr SHALL be taken in the same cycle (1-cycle redirect latency).

Reset
REQ-027 On rst: pc_reg = 32'hBFBF_FFFC; ce_reg = 0; br_pend = 0; br_pend_addr = 0; buffer state = PASS; buf_reg = 0; fetch_cnt = 0.
REQ-028 Outputs during reset SHALL be: inst_sram_en = 0; if_to_id_bus = {1'b0, 32'hBFBF_FFFC}; fetch_adel = 0; if_inst = inst_sram_rdata.
REQ-029 The first fetch after rst deasserts SHALL be 32'hBFC0_0000.
REQ-030 rst mid-stall or mid-pending SHALL discard the pending redirect and the buffered instruction.

Structure
REQ-031 StallBus, IF_TO_ID_WD, BR_WD, Stop/NoStop and the reset vector SHALL live in the shared defines header.
REQ-032 The instruction buffer SHALL be one sub-module, inst_hold_buf (clk, rst, hold, din, dout).

Verification
REQ-033 Reset: rst 3 cycles, release -> inst_sram_addr 0xBFC00000 with en=1; then 0xBFC00004 and 0xBFC00008 on successive cycles; fetch_cnt=3.
REQ-034 Branch: br_bus = {1, 0xBFC00100} at pc 0xBFC00008 -> next addr 0xBFC00100, with no cancelled slot.
REQ-035 Stalled branch: stall=6'b000011 for 3 cycles with br_e=1, addr 0x80000040 in cycle 1 only -> pc holds; after release, addr = 0x80000040.
REQ-036 ID hold: rdata=0x24020001, then stall[1]=Stop 2 cycles while rdata changes to 0xDEADBEEF -> if_inst stays 0x24020001 until the release cycle.
REQ-037 Misalign: br_addr=0xBFC00102 -> fetch_adel=1 for that fetch; the next sequential fetch is 0xBFC00106, also flagged.
REQ-038 Reset with br_pend=1 -> after release, first fetch is 0xBFC00000, not the latched target.
